// File: rtl/core_pkg.sv
// Shared pipeline-control types and constants for the 5-stage RV32 core.
package core_pkg;

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StMemWait = 3'd1,
        StDrain   = 3'd2,
        StHalted  = 3'd3,
        StError   = 3'd4
    } ctrl_state_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [4:0] REG_ZERO        = 5'd0;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic memwb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CtrlNone = '{
        pc_stall: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b0, idex_stall: 1'b0,
        idex_flush: 1'b0, exmem_stall: 1'b0, memwb_flush: 1'b0
    };

    // Whole pipeline frozen behind MEM; a bubble goes to WB while the access is pending.
    localparam pipe_ctrl_t CtrlFreeze = '{
        pc_stall: 1'b1, ifid_stall: 1'b1, ifid_flush: 1'b0, idex_stall: 1'b1,
        idex_flush: 1'b0, exmem_stall: 1'b1, memwb_flush: 1'b1
    };

    localparam pipe_ctrl_t CtrlRedirect = '{
        pc_stall: 1'b0, ifid_stall: 1'b0, ifid_flush: 1'b1, idex_stall: 1'b0,
        idex_flush: 1'b1, exmem_stall: 1'b0, memwb_flush: 1'b0
    };

    // Front end held, bubble injected into EX.
    localparam pipe_ctrl_t CtrlBubble = '{
        pc_stall: 1'b1, ifid_stall: 1'b1, ifid_flush: 1'b0, idex_stall: 1'b0,
        idex_flush: 1'b1, exmem_stall: 1'b0, memwb_flush: 1'b0
    };

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; the datapath is the master.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_is_load;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_req;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_stall;
    logic             memwb_flush;
    logic             halt_ack;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd, ex_reg_write,
               ex_is_load, ex_redirect, mem_req, mem_ready, halt_req,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
               memwb_flush, halt_ack, mem_timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd, ex_reg_write,
               ex_is_load, ex_redirect, mem_req, mem_ready, halt_req,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
               memwb_flush, halt_ack, mem_timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator between the ID instruction's sources and the load in EX.
module hazard_detect
    import core_pkg::*;
(
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_reg_write_i,
    input  logic       ex_is_load_i,
    output logic       load_use_o
);
    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1_i & (id_rs1_addr_i == ex_rd_i);
    assign rs2_hit = id_uses_rs2_i & (id_rs2_addr_i == ex_rd_i);

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use_o = ex_is_load_i & ex_reg_write_i & (ex_rd_i != REG_ZERO) &
                        (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, redirect, dmem wait, debug halt and timeout.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave bus
);
    localparam int unsigned        WaitW      = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned        DrainW     = $clog2(DRAIN_CYCLES + 1);
    localparam logic [WaitW-1:0]   WaitLimit  = WaitW'(MEM_TIMEOUT);
    localparam logic [DrainW-1:0]  DrainLimit = DrainW'(DRAIN_CYCLES);

    ctrl_state_e       state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    pipe_ctrl_t ctrl;
    logic       halt_ack;
    logic       timeout_err;
    logic       redirect_taken;
    logic       eval_run;
    logic       load_use;
    logic       mem_wait;

    hazard_detect u_hazard_detect (
        .id_rs1_addr_i  (bus.id_rs1_addr),
        .id_rs2_addr_i  (bus.id_rs2_addr),
        .id_uses_rs1_i  (bus.id_uses_rs1),
        .id_uses_rs2_i  (bus.id_uses_rs2),
        .ex_rd_i        (bus.ex_rd),
        .ex_reg_write_i (bus.ex_reg_write),
        .ex_is_load_i   (bus.ex_is_load),
        .load_use_o     (load_use)
    );

    assign mem_wait = bus.mem_req & ~bus.mem_ready;

    always_comb begin
        state_d        = state_q;
        wait_d         = '0;
        drain_d        = drain_q;
        ctrl           = CtrlNone;
        halt_ack       = 1'b0;
        timeout_err    = 1'b0;
        redirect_taken = 1'b0;
        eval_run       = 1'b0;

        unique case (state_q)
            // MemWait without a pending access is a release: EX was frozen, so re-run priority.
            StRun, StMemWait: eval_run = 1'b1;
            StDrain: begin
                if (mem_wait) begin
                    ctrl   = CtrlFreeze;
                    wait_d = wait_q + WaitW'(1);
                    if (wait_d >= WaitLimit) state_d = StError;
                end else if (!bus.halt_req) begin
                    eval_run = 1'b1;
                end else begin
                    ctrl    = CtrlBubble;
                    drain_d = drain_q + DrainW'(1);
                    if (drain_d >= DrainLimit) state_d = StHalted;
                end
            end
            StHalted: begin
                ctrl     = CtrlBubble;
                halt_ack = 1'b1;
                if (!bus.halt_req) state_d = StRun;
            end
            StError: begin
                ctrl        = CtrlFreeze;
                timeout_err = 1'b1;
            end
            default: state_d = StRun;
        endcase

        if (eval_run) begin
            state_d = StRun;
            drain_d = '0;
            if (mem_wait) begin
                ctrl    = CtrlFreeze;
                wait_d  = wait_q + WaitW'(1);
                state_d = (wait_d >= WaitLimit) ? StError : StMemWait;
            end else if (bus.ex_redirect) begin
                // The ID instruction is wrong-path, so any load-use against it is moot.
                ctrl           = CtrlRedirect;
                redirect_taken = 1'b1;
            end else if (load_use) begin
                ctrl = CtrlBubble;
            end else if (bus.halt_req) begin
                ctrl    = CtrlBubble;
                drain_d = DrainW'(1);
                state_d = (DRAIN_CYCLES <= 1) ? StHalted : StDrain;
            end
        end
    end

    assign stall_cnt_d = stall_cnt_q + CNT_W'(ctrl.pc_stall);
    assign flush_cnt_d = flush_cnt_q + CNT_W'(redirect_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_q      <= '0;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs are gated by reset so a live request cannot leak through while rst_n is low.
    assign bus.pc_stall        = rst_n & ctrl.pc_stall;
    assign bus.ifid_stall      = rst_n & ctrl.ifid_stall;
    assign bus.ifid_flush      = rst_n & ctrl.ifid_flush;
    assign bus.idex_stall      = rst_n & ctrl.idex_stall;
    assign bus.idex_flush      = rst_n & ctrl.idex_flush;
    assign bus.exmem_stall     = rst_n & ctrl.exmem_stall;
    assign bus.memwb_flush     = rst_n & ctrl.memwb_flush;
    assign bus.halt_ack        = rst_n & halt_ack;
    assign bus.mem_timeout_err = rst_n & timeout_err;
    assign bus.stall_cnt       = stall_cnt_q;
    assign bus.flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int MemTimeout  = 8;
    localparam int DrainCycles = 3;

    // Bit order: pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall memwb_flush
    //            halt_ack mem_timeout_err
    localparam logic [8:0] ExpNone     = 9'b000000000;
    localparam logic [8:0] ExpFreeze   = 9'b110101100;
    localparam logic [8:0] ExpRedirect = 9'b001010000;
    localparam logic [8:0] ExpBubble   = 9'b110010000;
    localparam logic [8:0] ExpHalted   = 9'b110010010;
    localparam logic [8:0] ExpError    = 9'b110101101;

    localparam int MRun = 0, MWait = 1, MDrain = 2, MHalt = 3, MErr = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned checks = 0;
    int unsigned errors = 0;

    hazard_ctrl_if #(.CNT_W(32)) bus ();

    hazard_ctrl #(
        .MEM_TIMEOUT  (MemTimeout),
        .DRAIN_CYCLES (DrainCycles),
        .CNT_W        (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [8:0] obs_vec;
    assign obs_vec = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_stall,
                      bus.idex_flush, bus.exmem_stall, bus.memwb_flush, bus.halt_ack,
                      bus.mem_timeout_err};

    int          m_mode, m_wait, m_drained;
    int unsigned m_stalls, m_flushes;
    int          n_mode, n_wait, n_drained;
    int unsigned n_stalls, n_flushes;
    logic [8:0]  exp_vec;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_eval();
        bit lu, mw;
        lu = bus.ex_is_load && bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
             ((bus.id_uses_rs1 && bus.id_rs1_addr == bus.ex_rd) ||
              (bus.id_uses_rs2 && bus.id_rs2_addr == bus.ex_rd));
        mw = bus.mem_req && !bus.mem_ready;
        n_mode = m_mode; n_wait = m_wait; n_drained = m_drained; n_flushes = m_flushes;
        exp_vec = ExpNone;
        if (m_mode == MErr) begin
            exp_vec = ExpError;
        end else if (m_mode == MHalt) begin
            exp_vec = ExpHalted;
            if (!bus.halt_req) n_mode = MRun;
        end else if (mw) begin
            exp_vec = ExpFreeze;
            n_wait  = m_wait + 1;
            if (n_wait >= MemTimeout) n_mode = MErr;
            else if (m_mode != MDrain) n_mode = MWait;
        end else if (m_mode == MDrain && bus.halt_req) begin
            exp_vec   = ExpBubble;
            n_wait    = 0;
            n_drained = m_drained + 1;
            if (n_drained >= DrainCycles) n_mode = MHalt;
        end else begin
            n_mode = MRun; n_wait = 0; n_drained = 0;
            if (bus.ex_redirect) begin
                exp_vec   = ExpRedirect;
                n_flushes = m_flushes + 1;
            end else if (lu) begin
                exp_vec = ExpBubble;
            end else if (bus.halt_req) begin
                exp_vec   = ExpBubble;
                n_drained = 1;
                n_mode    = (DrainCycles <= 1) ? MHalt : MDrain;
            end
        end
        n_stalls = m_stalls + 32'(exp_vec[8]);
    endtask

    // Inputs are set mid-cycle; sample just after, then advance past the next rising edge.
    task automatic cycle(string tag);
        #1;
        model_eval();
        check({tag, " ctl"}, 32'(obs_vec), 32'(exp_vec));
        check({tag, " stall_cnt"}, bus.stall_cnt, m_stalls);
        check({tag, " flush_cnt"}, bus.flush_cnt, m_flushes);
        m_mode = n_mode; m_wait = n_wait; m_drained = n_drained;
        m_stalls = n_stalls; m_flushes = n_flushes;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        #1;
        check({tag, " ctl"}, 32'(obs_vec), 32'(ExpNone));
        check({tag, " stall_cnt"}, bus.stall_cnt, 0);
        check({tag, " flush_cnt"}, bus.flush_cnt, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_mode = MRun; m_wait = 0; m_drained = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic set_idle();
        bus.id_rs1_addr = 5'd0; bus.id_rs2_addr = 5'd0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_rd = 5'd0; bus.ex_reg_write = 1'b0; bus.ex_is_load = 1'b0;
        bus.ex_redirect = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
        bus.halt_req = 1'b0;
    endtask

    task automatic set_load_use(logic [4:0] rd);
        bus.ex_rd = rd; bus.ex_reg_write = 1'b1; bus.ex_is_load = 1'b1;
        bus.id_uses_rs2 = 1'b1; bus.id_rs2_addr = rd;
    endtask

    initial begin
        int err_run;
        err_run = 0;
        set_idle();
        rst_n = 1'b1;
        bus.halt_req = 1'b1;
        #1;
        do_reset("reset");
        set_idle();

        set_load_use(5'd5);
        #1;
        check("lu pc_stall", 32'(bus.pc_stall), 1);
        check("lu idex_flush", 32'(bus.idex_flush), 1);
        cycle("lu");
        set_idle();
        #1;
        check("lu one cycle", 32'(bus.pc_stall), 0);
        cycle("lu after");
        set_load_use(5'd0);
        #1;
        check("lu x0", 32'(bus.pc_stall), 0);
        cycle("lu x0");

        set_load_use(5'd7);
        bus.ex_redirect = 1'b1;
        #1;
        check("redir pc_stall", 32'(bus.pc_stall), 0);
        check("redir ifid_flush", 32'(bus.ifid_flush), 1);
        check("redir flush_cnt before", bus.flush_cnt, 0);
        cycle("redir");
        set_idle();
        #1;
        check("redir flush_cnt after", bus.flush_cnt, 1);
        cycle("post redir");

        do_reset("pre memwait");
        bus.mem_req = 1'b1;
        repeat (4) cycle("memwait");
        bus.mem_ready = 1'b1;
        #1;
        check("memwait release", 32'(bus.pc_stall), 0);
        cycle("mem release");
        set_idle();
        #1;
        check("memwait stall_cnt", bus.stall_cnt, 4);
        cycle("post memwait");

        do_reset("pre timeout");
        bus.mem_req = 1'b1;
        repeat (MemTimeout) cycle("timeout wait");
        #1;
        check("timeout err", 32'(bus.mem_timeout_err), 1);
        cycle("error");
        bus.mem_ready = 1'b1;
        repeat (2) cycle("error held");
        #1;
        check("error sticky", 32'(bus.mem_timeout_err), 1);
        do_reset("error reset");
        set_idle();

        bus.halt_req = 1'b1;
        repeat (DrainCycles) begin
            #1;
            check("drain no ack", 32'(bus.halt_ack), 0);
            cycle("drain");
        end
        #1;
        check("halt ack", 32'(bus.halt_ack), 1);
        cycle("halted");
        bus.halt_req = 1'b0;
        cycle("halt drop");
        #1;
        check("resume ack", 32'(bus.halt_ack), 0);
        check("resume pc_stall", 32'(bus.pc_stall), 0);
        cycle("resumed");

        bus.halt_req = 1'b1;
        repeat (2) cycle("drain pre rst");
        do_reset("mid drain reset");
        repeat (DrainCycles) cycle("redrain");
        #1;
        check("redrain ack", 32'(bus.halt_ack), 1);
        cycle("rehalted");
        set_idle();
        cycle("idle");

        for (int i = 0; i < 1500; i++) begin
            bus.ex_rd        = 5'($urandom_range(0, 3));
            bus.id_rs1_addr  = 5'($urandom_range(0, 3));
            bus.id_rs2_addr  = 5'($urandom_range(0, 3));
            bus.id_uses_rs1  = 1'($urandom_range(0, 1));
            bus.id_uses_rs2  = 1'($urandom_range(0, 1));
            bus.ex_reg_write = 1'($urandom_range(0, 1));
            bus.ex_is_load   = 1'($urandom_range(0, 1));
            bus.ex_redirect  = ($urandom_range(0, 7) == 0);
            if (m_mode == MWait) begin
                bus.mem_req   = 1'b1;
                bus.mem_ready = ($urandom_range(0, 2) == 0);
            end else begin
                bus.mem_req   = ($urandom_range(0, 2) == 0);
                bus.mem_ready = ($urandom_range(0, 2) != 0);
            end
            if ($urandom_range(0, 9) == 0) bus.halt_req = ~bus.halt_req;
            if (m_mode == MErr) begin
                err_run++;
                if (err_run > 2) begin
                    err_run = 0;
                    do_reset("rand reset");
                end
            end
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
